// File: rtl/vc_input_port.sv
// Virtual-channel input port: one first-word-fall-through FIFO per VC, a
// round-robin packet arbiter that locks onto one VC for a whole packet,
// per-VC credit return and a sticky overflow flag.

package chiplet_types_pkg;
  // Packet format codes carried in payload[31:28] of a head flit.
  typedef enum logic [3:0] {
    FMT_SHORT_READ  = 4'h0,
    FMT_SHORT_WRITE = 4'h1,
    FMT_LONG_READ   = 4'h2,
    FMT_LONG_WRITE  = 4'h3
  } flit_fmt_e;
endpackage

module vc_input_port
  import chiplet_types_pkg::*;
#(
  parameter  int NUM_VCS    = 2,
  parameter  int DEPTH      = 8,
  parameter  int FLIT_WIDTH = 64,
  localparam int VCW        = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  in_valid,
  input  logic [VCW-1:0]        in_vc,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  output logic [NUM_VCS-1:0]    buffer_available,
  output logic [NUM_VCS-1:0]    credit_return,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic [VCW-1:0]        out_vc,
  output logic                  out_head,
  output logic                  out_tail,
  output logic                  overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  // Packet length in flits, decoded from the head flit's format and length bits.
  function automatic logic [7:0] pkt_len_f(input logic [3:0] fmt, input logic [6:0] len);
    case (fmt)
      FMT_SHORT_READ:  pkt_len_f = 8'd1;
      FMT_SHORT_WRITE: pkt_len_f = 8'd1 + {4'd0, len[3:0]};
      FMT_LONG_READ:   pkt_len_f = 8'd2;
      FMT_LONG_WRITE:  pkt_len_f = 8'd2 + {1'b0, len};
      default:         pkt_len_f = 8'd1 + {1'b0, len};
    endcase
  endfunction

  logic [FLIT_WIDTH-1:0] mem_q      [NUM_VCS][DEPTH];
  logic [PW-1:0]         wr_ptr_q   [NUM_VCS];
  logic [PW-1:0]         rd_ptr_q   [NUM_VCS];
  logic [CW-1:0]         count_q    [NUM_VCS];
  state_e                state_q;
  logic [VCW-1:0]        grant_q;
  logic [VCW-1:0]        last_q;
  logic                  head_pending_q;
  logic [7:0]            remaining_q;
  logic                  overflow_q;
  logic [NUM_VCS-1:0]    credit_q;

  logic [NUM_VCS-1:0]    full;
  logic [NUM_VCS-1:0]    empty;
  logic [NUM_VCS-1:0]    wr_en;
  logic [NUM_VCS-1:0]    rd_en;
  logic                  wr_drop;
  logic                  deq;
  logic                  is_tail;
  logic [7:0]            pkt_len;
  logic                  pick_found;
  logic [VCW-1:0]        pick_vc;

  // FIFO status and per-VC write/read enables; fullness uses start-of-cycle counts.
  always_comb begin
    // NOTE: every variable gets a default before any conditional so no latch is inferred.
    wr_drop = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      full[v]  = (count_q[v] == CW'(DEPTH));
      empty[v] = (count_q[v] == '0);
      wr_en[v] = in_valid && (in_vc == VCW'(v)) && !full[v];
      rd_en[v] = deq && (grant_q == VCW'(v));
      wr_drop  = wr_drop | (in_valid && (in_vc == VCW'(v)) && full[v]);
    end
  end

  // Round-robin pick: first non-empty VC after the last granted one.
  always_comb begin
    pick_found = 1'b0;
    pick_vc    = '0;
    for (int i = 1; i <= NUM_VCS; i++) begin
      if (!pick_found && !empty[(int'(last_q) + i) % NUM_VCS]) begin
        pick_found = 1'b1;
        pick_vc    = VCW'((int'(last_q) + i) % NUM_VCS);
      end
    end
  end

  assign out_flit         = mem_q[grant_q][rd_ptr_q[grant_q]];
  assign out_vc           = grant_q;
  assign out_valid        = (state_q == LOCKED) && !empty[grant_q];
  assign deq              = out_valid && out_ready;
  assign pkt_len          = pkt_len_f(out_flit[31:28], out_flit[6:0]);
  assign is_tail          = head_pending_q ? (pkt_len == 8'd1) : (remaining_q == 8'd1);
  assign out_head         = out_valid && head_pending_q;
  assign out_tail         = out_valid && is_tail;
  assign buffer_available = ~full;
  assign credit_return    = credit_q;
  assign overflow_err     = overflow_q;

  // Flit storage; a write lands at the tail and is readable from the next cycle.
  // NOTE: storage is not reset; counts and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (wr_en[v]) mem_q[v][wr_ptr_q[v]] <= in_flit;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        count_q[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (wr_en[v]) wr_ptr_q[v] <= wr_ptr_q[v] + 1'b1;
        if (rd_en[v]) rd_ptr_q[v] <= rd_ptr_q[v] + 1'b1;
        count_q[v] <= count_q[v] + CW'(wr_en[v]) - CW'(rd_en[v]);
      end
    end
  end

  // Packet arbiter: grant a VC in IDLE, hold it in LOCKED until the tail leaves.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      last_q         <= VCW'(NUM_VCS - 1);
      head_pending_q <= 1'b0;
      remaining_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q        <= pick_vc;
            head_pending_q <= 1'b1;
            state_q        <= LOCKED;
          end
        end
        LOCKED: begin
          if (deq) begin
            if (head_pending_q) begin
              head_pending_q <= 1'b0;
              remaining_q    <= pkt_len - 8'd1;
            end else begin
              remaining_q    <= remaining_q - 8'd1;
            end
            if (is_tail) begin
              state_q <= IDLE;
              last_q  <= grant_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Credit pulse the cycle after each dequeue, and sticky overflow on a dropped write.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      credit_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      credit_q <= rd_en;
      if (wr_drop) overflow_q <= 1'b1;
    end
  end

endmodule
